// File: rtl/fibonacci_seq_gen_if.sv
// Term stream interface for fibonacci_seq_gen: valid/ready beat carrying term, index and last flag.
interface fibonacci_seq_gen_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_term;
  logic [CNT_W-1:0] out_idx;
  logic             out_last;

  modport master (
    output out_valid, out_term, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_term, out_idx, out_last,
    output out_ready
  );
endinterface

// File: rtl/fibonacci_seq_gen.sv
// Start/done controlled Fibonacci term generator streaming terms on a valid/ready interface.
// Optional FIB_SEED_EN adds seed0/seed1 inputs captured at start; otherwise the series starts 1,1.
module fibonacci_seq_gen #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
`ifdef FIB_SEED_EN
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
`endif
  fibonacci_seq_gen_if.master out_if,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b;
  logic             b_carry;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] n_reg;
  logic [WIDTH:0]   nxt;
  logic             idx_end;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] s0, s1;

`ifdef FIB_SEED_EN
  assign s0 = seed0;
  assign s1 = seed1;
`else
  assign s0 = WIDTH'(1);
  assign s1 = WIDTH'(1);
`endif

  // b_carry marks b as unrepresentable, so the current term a ends the stream.
  always_comb begin
    nxt     = {1'b0, a} + {1'b0, b};
    idx_end = (idx == (n_reg - CNT_W'(1)));
    last    = idx_end | b_carry;
    accept  = (state == EMIT) & out_if.out_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (n_terms != '0) ? EMIT : DONE;
      EMIT: if (accept && last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a       <= '0;
      b       <= '0;
      b_carry <= 1'b0;
      idx     <= '0;
      n_reg   <= '0;
      ovf     <= 1'b0;
    end else if (state == IDLE && start) begin
      a       <= s0;
      b       <= s1;
      b_carry <= 1'b0;
      idx     <= '0;
      n_reg   <= n_terms;
      ovf     <= 1'b0;
    end else if (accept) begin
      if (last) begin
        ovf <= ~idx_end;
      end else begin
        a       <= b;
        b       <= nxt[WIDTH-1:0];
        b_carry <= nxt[WIDTH];
        idx     <= idx + CNT_W'(1);
      end
    end
  end

  assign out_if.out_valid = (state == EMIT);
  assign out_if.out_term  = a;
  assign out_if.out_idx   = idx;
  assign out_if.out_last  = (state == EMIT) & last;
  assign busy             = (state != IDLE);
  assign done             = (state == DONE);

endmodule

// File: tb/tb_fibonacci_seq_gen.sv
// Self-checking bench for fibonacci_seq_gen: directed and random runs against a series model.
module tb_fibonacci_seq_gen;
  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] n_terms = '0;
  logic [WIDTH-1:0] seed0 = WIDTH'(1);
  logic [WIDTH-1:0] seed1 = WIDTH'(1);
  logic             busy, done, ovf;

  fibonacci_seq_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) sif ();

  fibonacci_seq_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .n_terms (n_terms),
`ifdef FIB_SEED_EN
    .seed0   (seed0),
    .seed1   (seed1),
`endif
    .out_if  (sif.master),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_term[$];
  bit               exp_ovf;

  logic [WIDTH-1:0] obs_term[$];
  logic [CNT_W-1:0] obs_idx[$];
  logic             obs_last[$];
  int  done_cyc, last_acc_cyc, stall_err;
  bit  timed_out, first_valid, ovf_at_done, valid_at_done, busy_after;
  logic [CNT_W-1:0] first_idx;

  // Series from its definition: each term is the sum of the two before; stop at the first
  // term that does not fit in WIDTH bits.
  task automatic model(input int n, input longint s0, input longint s1);
    longint t0, t1, t;
    t0 = s0; t1 = s1;
    exp_term.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (t0 >= (longint'(1) << WIDTH)) begin
        exp_ovf = 1'b1;
        break;
      end
      exp_term.push_back(t0[WIDTH-1:0]);
      t  = t0 + t1;
      t0 = t1;
      t1 = t;
    end
  endtask

  // Drive one run and record what the sink saw. mode 0: ready=1, 1: random, 2: 1,0,0 pattern.
  task automatic do_run(input int n, input int mode, input int inj_idx);
    logic [WIDTH-1:0] p_term;
    logic [CNT_W-1:0] p_idx;
    logic             p_last;
    bit stall_prev, injected;
    int cyc;
    obs_term.delete(); obs_idx.delete(); obs_last.delete();
    done_cyc = -1; last_acc_cyc = -1; stall_err = 0; timed_out = 1'b1;
    stall_prev = 1'b0; injected = 1'b0;
    p_term = '0; p_idx = '0; p_last = 1'b0;
    start = 1'b1;
    n_terms = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    first_valid = sif.out_valid;
    first_idx   = sif.out_idx;
    for (cyc = 0; cyc < 3000; cyc++) begin
      case (mode)
        0:       sif.out_ready = 1'b1;
        1:       sif.out_ready = 1'($urandom_range(0, 1));
        default: sif.out_ready = ((cyc % 3) == 0);
      endcase
      if (inj_idx >= 0 && !injected && sif.out_valid && sif.out_idx == CNT_W'(inj_idx)) begin
        start = 1'b1;
        n_terms = CNT_W'(3);
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (stall_prev && (sif.out_term !== p_term || sif.out_idx !== p_idx ||
                         sif.out_last !== p_last || sif.out_valid !== 1'b1))
        stall_err++;
      if (sif.out_valid && sif.out_ready) begin
        obs_term.push_back(sif.out_term);
        obs_idx.push_back(sif.out_idx);
        obs_last.push_back(sif.out_last);
        last_acc_cyc = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        ovf_at_done = ovf;
        valid_at_done = sif.out_valid;
        timed_out = 1'b0;
        break;
      end
      stall_prev = sif.out_valid & ~sif.out_ready;
      p_term = sif.out_term; p_idx = sif.out_idx; p_last = sif.out_last;
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    busy_after = busy;
  endtask

  task automatic test_reset;
    checks++;
    if ({sif.out_valid, sif.out_term, sif.out_idx, sif.out_last, busy, done, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b t=%0d i=%0d l=%b busy=%b done=%b ovf=%b want all 0",
               sif.out_valid, sif.out_term, sif.out_idx, sif.out_last, busy, done, ovf);
    end
  endtask

  task automatic test_run(input string name, input int n, input int mode, input int inj_idx);
    model(n, longint'(seed0), longint'(seed1));
    do_run(n, mode, inj_idx);
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL %s timeout got no done want done", name);
    end
    checks++;
    if (obs_term.size() != exp_term.size()) begin
      errors++;
      $display("FAIL %s beat_count got %0d want %0d", name, obs_term.size(), exp_term.size());
    end
    for (int i = 0; i < obs_term.size() && i < exp_term.size(); i++) begin
      checks++;
      if (obs_term[i] !== exp_term[i] || obs_idx[i] !== CNT_W'(i) ||
          obs_last[i] !== (i == exp_term.size() - 1)) begin
        errors++;
        $display("FAIL %s beat%0d got term=%0d idx=%0d last=%b want term=%0d idx=%0d last=%b",
                 name, i, obs_term[i], obs_idx[i], obs_last[i], exp_term[i], i,
                 (i == exp_term.size() - 1));
      end
    end
    checks++;
    if (n > 0 && (first_valid !== 1'b1 || first_idx !== '0)) begin
      errors++;
      $display("FAIL %s latency got valid=%b idx=%0d want valid=1 idx=0", name, first_valid, first_idx);
    end else if (n == 0 && first_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s latency got valid=%b want valid=0", name, first_valid);
    end
    checks++;
    if (!timed_out && done_cyc != ((n == 0) ? 0 : last_acc_cyc + 1)) begin
      errors++;
      $display("FAIL %s done_timing got cyc %0d want %0d", name, done_cyc,
               (n == 0) ? 0 : last_acc_cyc + 1);
    end
    checks++;
    if (!timed_out && (ovf_at_done !== exp_ovf || valid_at_done !== 1'b0 || busy_after !== 1'b0)) begin
      errors++;
      $display("FAIL %s end_state got ovf=%b valid=%b busy_after=%b want ovf=%b valid=0 busy_after=0",
               name, ovf_at_done, valid_at_done, busy_after, exp_ovf);
    end
    checks++;
    if (stall_err != 0) begin
      errors++;
      $display("FAIL %s stall_hold got %0d changes want 0", name, stall_err);
    end
  endtask

  task automatic test_basic;            test_run("basic10", 10, 0, -1);  endtask
  task automatic test_overflow;         test_run("ovf30", 30, 0, -1);    endtask
  task automatic test_backpressure;
    test_run("bp6_pattern", 6, 2, -1);
    test_run("bp6_random", 6, 1, -1);
  endtask
  task automatic test_zero_one;
    test_run("n0", 0, 0, -1);
    test_run("n1", 1, 0, -1);
  endtask
  task automatic test_start_busy;       test_run("start_busy", 10, 0, 3); endtask

  task automatic test_reset_mid;
    int k;
    bit seen_done;
    start = 1'b1;
    n_terms = CNT_W'(10);
    sif.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (k = 0; k < 50; k++) begin
      if (sif.out_valid && sif.out_idx == CNT_W'(5)) break;
      @(posedge clk); #1;
    end
    checks++;
    if (k == 50) begin
      errors++;
      $display("FAIL reset_mid reach_idx5 got timeout want idx5");
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({sif.out_valid, sif.out_term, sif.out_idx, sif.out_last, busy, done, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs got v=%b t=%0d i=%0d l=%b busy=%b done=%b want all 0",
               sif.out_valid, sif.out_term, sif.out_idx, sif.out_last, busy, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done || busy || sif.out_valid) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL reset_mid idle_after got activity want idle, no done");
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      int n;
      n = (r % 4 == 3) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 30));
      test_run($sformatf("rand%0d_n%0d", r, n), n, 1, -1);
    end
  endtask

`ifdef FIB_SEED_EN
  task automatic test_seed;
    seed0 = WIDTH'(2);
    seed1 = WIDTH'(1);
    test_run("lucas6", 6, 0, -1);
    seed0 = WIDTH'($urandom);
    seed1 = WIDTH'($urandom);
    test_run("seed_rand", 20, 1, -1);
    seed0 = WIDTH'(1);
    seed1 = WIDTH'(1);
  endtask
`endif

  initial begin
    sif.out_ready = 1'b1;
    #1;
    test_reset;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic;
    test_overflow;
    test_backpressure;
    test_zero_one;
    test_start_busy;
    test_reset_mid;
    test_random;
`ifdef FIB_SEED_EN
    test_seed;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
